// File: rtl/sum_accumulator_pkg.sv
// Shared types and widths for the sum_accumulator slice.
// Optional feature macro used by the top: SUM_ACCUMULATOR_SATURATE_EN.
package sum_accumulator_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accumulator_adder.sv
// adder_16bit: combinational unsigned add with carry-in; overflow is the carry-out.
module adder_16bit
  import sum_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  logic [DATA_W:0] full_s;

  assign full_s   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
  assign sum      = full_s[DATA_W-1:0];
  assign overflow = full_s[DATA_W];

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums NUM_SAMPLES handshaked beats and holds the result until consumed.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp the running total at 16'hFFFF on carry-out.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter  int NUM_SAMPLES = 4,
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  state_e            state_r;
  logic [DATA_W-1:0] acc_r;
  logic              sticky_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] out_sum_r;
  logic              out_overflow_r;
  logic              out_valid_r;

  logic [DATA_W-1:0] add_sum_s;
  logic              add_ovf_s;
  logic [DATA_W-1:0] acc_next_s;
  logic              sticky_next_s;
  logic              last_beat_s;

  adder_16bit u_adder (
    .a        (acc_r),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (add_sum_s),
    .overflow (add_ovf_s)
  );

  // Next running total: wrap or clamp depending on build
  always_comb begin
    acc_next_s = add_sum_s;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    if (add_ovf_s) begin
      acc_next_s = {DATA_W{1'b1}};
    end else begin
      acc_next_s = add_sum_s;
    end
`endif
  end

  assign sticky_next_s = sticky_r | add_ovf_s;
  assign last_beat_s   = (count_r == LAST_CNT);
  assign in_ready      = (state_r != HOLD);

  assign out_sum      = out_sum_r;
  assign out_overflow = out_overflow_r;
  assign out_valid    = out_valid_r;
  assign count        = count_r;

  // Frame FSM with accumulator, beat counter and registered result port
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      acc_r          <= {DATA_W{1'b0}};
      sticky_r       <= 1'b0;
      count_r        <= {CNT_W{1'b0}};
      out_sum_r      <= {DATA_W{1'b0}};
      out_overflow_r <= 1'b0;
      out_valid_r    <= 1'b0;
    end else if (clear) begin
      state_r        <= IDLE;
      acc_r          <= {DATA_W{1'b0}};
      sticky_r       <= 1'b0;
      count_r        <= {CNT_W{1'b0}};
      out_sum_r      <= {DATA_W{1'b0}};
      out_overflow_r <= 1'b0;
      out_valid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc_r    <= acc_next_s;
            sticky_r <= sticky_next_s;
            if (last_beat_s) begin
              state_r        <= HOLD;
              out_sum_r      <= acc_next_s;
              out_overflow_r <= sticky_next_s;
              out_valid_r    <= 1'b1;
              count_r        <= {CNT_W{1'b0}};
            end else begin
              state_r <= ACCUM;
              count_r <= count_r + CNT_W'(1);
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          // Incoming beats are ignored until the result is taken
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            acc_r       <= {DATA_W{1'b0}};
            sticky_r    <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= {DATA_W{1'b0}};
          sticky_r    <= 1'b0;
          count_r     <= {CNT_W{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (NUM_SAMPLES=4): directed plan plus random traffic
// against a frame-level arithmetic model.
module tb_sum_accumulator;

  localparam int N = 4;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_sum;
  logic        out_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_acc, m_cnt, m_osum;
  bit m_stk, m_hold, m_oovf;

  sum_accumulator #(.NUM_SAMPLES(N)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_osum = 0;
    m_stk = 0; m_hold = 0; m_oovf = 0;
  endtask

  // Apply the spec rules to the inputs seen at the coming edge
  task automatic model_edge();
    int t;
    if (clear) begin
      model_reset();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0; m_acc = 0; m_stk = 0;
      end
    end else if (in_valid) begin
      t = m_acc + int'(in_data);
      if (t > 65535) begin
        m_stk = 1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        t = 65535;
`else
        t = t - 65536;
`endif
      end
      m_acc = t;
      m_cnt = m_cnt + 1;
      if (m_cnt == N) begin
        m_hold = 1; m_osum = m_acc; m_oovf = m_stk; m_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("in_ready",     32'(in_ready),     32'(!m_hold));
    check("out_valid",    32'(out_valid),    32'(m_hold));
    check("out_sum",      32'(out_sum),      32'(m_osum));
    check("out_overflow", 32'(out_overflow), 32'(m_oovf));
    check("count",        32'(count),        32'(m_cnt));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    tick();
  endtask

  task automatic take_result();
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int stable_sum;
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Reset mid-frame
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    check("mid_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Basic frame
    for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
    check("basic_sum", 32'(out_sum), 32'h000A);
    check("basic_valid", 32'(out_valid), 32'd1);

    // Backpressure: result held, incoming 7s ignored
    stable_sum = int'(out_sum);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0007, 1'b0, 1'b0);
      check("bp_stable", 32'(out_sum), 32'(stable_sum));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    check("bp_done_valid", 32'(out_valid), 32'd0);
    check("bp_done_ready", 32'(in_ready), 32'd1);

    // Wrap frame
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    check("wrap_sum", 32'(out_sum), 32'h0000FFFF);
`else
    check("wrap_sum", 32'(out_sum), 32'h00000000);
`endif
    check("wrap_ovf", 32'(out_overflow), 32'd1);
    take_result();

    // Bubbles between beats
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      check("bubble_count", 32'(count), 32'(i % 4));
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
    end
    check("bubble_sum", 32'(out_sum), 32'h000A);
    take_result();

    // Clear drops a concurrent beat
    drive(1'b1, 16'h0009, 1'b0, 1'b0);
    drive(1'b1, 16'h0009, 1'b0, 1'b0);
    drive(1'b1, 16'h0009, 1'b0, 1'b1);
    check("clear_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0005, 1'b0, 1'b0);
    check("clear_sum", 32'(out_sum), 32'h0014);
    check("clear_ovf", 32'(out_overflow), 32'd0);
    take_result();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      d = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(15, 0)) : 16'($urandom);
      drive(($urandom_range(3, 0) != 0), d, ($urandom_range(1, 0) == 1),
            ($urandom_range(39, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
